multih_sym_sequencer: RTL and testbench
=======================================

# multih_sym_sequencer

Symbol-timing sequencer for the multi-h trellis demodulator. It generates the `symEn`, `sym2xEn` and `symEnEven` strobe pattern that drives `trellisMultiH`, with programmable per-parity symbol periods and mid-symbol sample offset. It also buffers incoming I/Q samples in a 4-deep FIFO and releases exactly one sample per `sym2xEn` strobe, aligned with the strobe. It sits between the front-end resampler and the trellis, replacing hand-built strobe counters.

## Interface
- `DATA_W`, 18, I and Q sample width (two's complement).
- `CNT_W`, 8, width of the period and offset configuration fields.
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous, active-low reset.
- `run` in 1: enables sequencing; low means idle.
- `flush` in 1: synchronous FIFO clear.
- `symPeriodEven` in CNT_W: clocks per even symbol.
- `symPeriodOdd` in CNT_W: clocks per odd symbol.
- `midOffset` in CNT_W: clocks from the symbol strobe to the mid-symbol strobe.
- `iIn`, `qIn` in DATA_W: upstream sample.
- `inValid` in 1: upstream sample is valid.
- `inReady` out 1: FIFO can accept a sample; equals not-full.
- `symEn`, `sym2xEn`, `symEnEven` out 1: strobes to the trellis.
- `iOut`, `qOut` out DATA_W: sample presented with `sym2xEn`.
- `underflow` out 1: sticky flag; sets when a strobe finds the FIFO empty.
- `underflowCnt` out 8: saturating underflow count (only with the macro; see Configuration).

## Operation
- States: IDLE, RUN.
  - IDLE → RUN when `run`=1.
  - RUN → IDLE when `run`=0, taking effect on the same cycle. Any symbol in progress is abandoned and no strobe is issued for it.
- On entering RUN, `phaseCnt` is 0 and `parity` is even.
- In RUN, `phaseCnt` counts 0..P-1, where P is the latched period for the current parity. At wrap, `parity` toggles.
- Period handling:
  - `symPeriodEven`, `symPeriodOdd` and `midOffset` are latched at every `phaseCnt`==0. Changes therefore take effect only at symbol boundaries.
  - A latched period below 4 is treated as 4.
  - A latched `midOffset` of 0 or ≥ P is treated as P>>1.
- Strobes, each one clock wide:
  - At `phaseCnt`==0: `symEn`=1 and `sym2xEn`=1. `symEnEven`=1 as well when `parity` is even.
  - At `phaseCnt`==`midOffset`: `sym2xEn`=1 only.
- FIFO:
  - Depth 4.
  - Push when `inValid` and `inReady` are both 1.
  - Pop on every cycle where `sym2xEn` is issued.
  - On a pop from a non-empty FIFO, `iOut`/`qOut` take the head entry.
  - On a pop from an empty FIFO, `iOut`/`qOut` hold their previous value, the strobe is still issued, and `underflow` sets.
- Simultaneous events:
  - Push and pop when full: the push is blocked, because `inReady` was 0.
  - Push and pop when empty: this is an underflow. There is no bypass; the pushed sample is the next head.
  - `flush`: empties the FIFO and has priority over a push in the same cycle. A pop in the same cycle behaves as a pop from empty. `flush` does not clear `underflow`.
- `underflow` clears only on reset or on an IDLE→RUN transition.
- Reset values: all outputs 0. `inReady`=1 after the first clock following reset release. FIFO is empty, state is IDLE, `parity` is even.

## Timing
- First strobe: on the first rising edge with `run`=1 in IDLE, the registered `symEn`/`sym2xEn`/`symEnEven` are 1 in the following cycle, which is the cycle with `phaseCnt`=0.
- Strobes and `iOut`/`qOut` are registered and change together. Data is valid in exactly the strobe cycle and holds until the next strobe.
- A sample pushed at edge t is eligible for a pop at edge t+1 or later.
- `inReady` reflects FIFO occupancy after the current edge's push and pop.
- Asynchronous reset during RUN clears every output immediately, independent of `clk`.

## Configuration
- Macro `MULTIH_SEQ_UNDERFLOW_CNT_EN`.
  - Defined: `underflowCnt` is an 8-bit counter that increments on each underflow pop, saturates at 255, and clears together with `underflow`.
  - Undefined: the `underflowCnt` port and the counter are absent. `underflow` behaves identically in both builds.

## Test plan
- Nominal pattern: `symPeriodEven`=10, `symPeriodOdd`=9, `midOffset`=2, FIFO kept non-empty.
  - Required: `symEn` at cycles 0, 10, 19, 29…; `sym2xEn` also at 2, 12, 21…; `symEnEven` at 0, 19, 38….
  - Samples emerge in push order.
- Clamping:
  - `symPeriodOdd`=2 → odd symbols last 4 clocks.
  - `midOffset`=12 with period 10 → mid strobe at offset 5.
- Underflow: run with an empty FIFO.
  - Required: strobes continue; `iOut`=0 held; `underflow`=1; `underflowCnt` increments once per strobe and saturates at 255 after 255 strobes.
- Backpressure: hold `inValid`=1 with strobes stopped (`run`=0).
  - Required: exactly 4 samples accepted, then `inReady`=0. `inReady` rises in the cycle after the first pop.
- Mid-run events:
  - A config change mid-symbol takes effect only at the next `symEn`.
  - `run` dropped at `phaseCnt`=1 → no mid strobe.
  - Restarting → `symEnEven` on the first strobe and `underflow` cleared.
- Async reset asserted between clock edges during RUN → all outputs 0 immediately; FIFO empty afterwards.

Source files
------------

// File: rtl/multih_sym_sequencer_if.sv
// ---------------------------------------------------------------------------
// multih_sym_sequencer_if
//
// Sample/strobe bus between the front-end resampler, the symbol sequencer
// and the multi-h trellis.
//
//   iIn, qIn   : upstream I/Q sample (two's complement, DATA_W bits)
//   inValid    : upstream sample is valid
//   inReady    : sequencer FIFO can accept a sample (not full)
//   symEn      : symbol strobe
//   sym2xEn    : symbol and mid-symbol strobe
//   symEnEven  : symbol strobe on even symbols only
//   iOut, qOut : sample released together with sym2xEn
//
// Modports:
//   slave  - the sequencer (consumes samples, produces strobes)
//   master - the surrounding logic (produces samples, consumes strobes)
// ---------------------------------------------------------------------------
interface multih_sym_sequencer_if #(
  parameter int DATA_W = 18
);
  logic [DATA_W-1:0] iIn;
  logic [DATA_W-1:0] qIn;
  logic              inValid;
  logic              inReady;
  logic              symEn;
  logic              sym2xEn;
  logic              symEnEven;
  logic [DATA_W-1:0] iOut;
  logic [DATA_W-1:0] qOut;

  modport slave (
    input  iIn, qIn, inValid,
    output inReady, symEn, sym2xEn, symEnEven, iOut, qOut
  );

  modport master (
    output iIn, qIn, inValid,
    input  inReady, symEn, sym2xEn, symEnEven, iOut, qOut
  );
endinterface

// File: rtl/multih_sym_sequencer.sv
// ---------------------------------------------------------------------------
// multih_sym_sequencer
//
// Symbol-timing sequencer for the multi-h trellis demodulator. Generates the
// symEn / sym2xEn / symEnEven strobe pattern with programmable per-parity
// symbol periods and mid-symbol offset, and releases one buffered I/Q sample
// (4-deep FIFO) with every sym2xEn strobe.
//
// Ports:
//   clk            : system clock
//   resetN         : asynchronous active-low reset
//   run            : 1 = sequence strobes, 0 = idle (takes effect at the edge)
//   flush          : synchronous FIFO clear (wins over a push)
//   symPeriodEven  : clocks per even symbol (values below 4 run as 4)
//   symPeriodOdd   : clocks per odd symbol  (values below 4 run as 4)
//   midOffset      : clocks from symbol strobe to mid strobe
//                    (0 or >= period runs as period/2)
//   bus            : sample/strobe bus, slave side (see the interface file)
//   underflow      : sticky; set when a strobe finds the FIFO empty,
//                    cleared by reset or by starting a new run
//   underflowCnt   : saturating underflow count, present only when
//                    MULTIH_SEQ_UNDERFLOW_CNT_EN is defined
//
// Configuration macro: MULTIH_SEQ_UNDERFLOW_CNT_EN
// ---------------------------------------------------------------------------
module multih_sym_sequencer #(
  parameter int DATA_W = 18,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  run,
  input  logic                  flush,
  input  logic [CNT_W-1:0]      symPeriodEven,
  input  logic [CNT_W-1:0]      symPeriodOdd,
  input  logic [CNT_W-1:0]      midOffset,
  multih_sym_sequencer_if.slave bus,
  output logic                  underflow
`ifdef MULTIH_SEQ_UNDERFLOW_CNT_EN
  ,
  output logic [7:0]            underflowCnt
`endif
);

  typedef enum logic {IDLE, RUN} stateT;

  localparam int               DEPTH      = 4;
  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(4);

  // ---------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------
  stateT             state;
  logic              parity;      // 0 = even symbol, 1 = odd symbol
  logic [CNT_W-1:0]  phaseCnt;
  logic [CNT_W-1:0]  latEven;
  logic [CNT_W-1:0]  latOdd;
  logic [CNT_W-1:0]  latMid;

  logic              symEnR;
  logic              sym2xEnR;
  logic              symEnEvenR;
  logic [DATA_W-1:0] iOutR;
  logic [DATA_W-1:0] qOutR;

  logic [CNT_W-1:0]  curPeriod;
  logic [CNT_W-1:0]  effPeriod;
  logic [CNT_W-1:0]  effMid;
  logic [CNT_W-1:0]  phaseInc;

  logic              startSym;
  logic              midSym;
  logic              popReq;
  logic              enterRun;
  logic              nextParity;
  logic [CNT_W-1:0]  nextPhase;

  // Effective timing for the symbol in progress, from the values captured
  // when that symbol started. A period of at least 4 keeps the mid strobe
  // (>= 2) clear of the symbol strobe.
  always_comb begin
    curPeriod = parity ? latOdd : latEven;
    effPeriod = (curPeriod < MIN_PERIOD) ? MIN_PERIOD : curPeriod;
    effMid    = (latMid == '0 || latMid >= effPeriod) ? (effPeriod >> 1) : latMid;
    phaseInc  = phaseCnt + CNT_W'(1);
  end

  // Strobe decisions are made for the cycle after the coming edge, so the
  // strobe registers line up with phaseCnt in the cycle they are high.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    startSym   = 1'b0;
    midSym     = 1'b0;
    nextParity = parity;
    nextPhase  = phaseCnt;
    if (run) begin
      if (state == IDLE) begin
        startSym   = 1'b1;
        nextParity = 1'b0;
        nextPhase  = '0;
      end else if (phaseCnt == effPeriod - CNT_W'(1)) begin
        startSym   = 1'b1;
        nextParity = ~parity;
        nextPhase  = '0;
      end else begin
        nextPhase  = phaseInc;
        midSym     = (phaseInc == effMid);
      end
    end
  end

  assign popReq   = startSym | midSym;
  assign enterRun = (state == IDLE) & run;

  // ---------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] memI [DEPTH];
  logic [DATA_W-1:0] memQ [DEPTH];
  logic [1:0]        wrPtr;
  logic [1:0]        rdPtr;
  logic [2:0]        count;
  logic [2:0]        countNext;
  logic              inReadyR;
  logic              pushEn;
  logic              popEn;
  logic              popEmpty;

  // Pops look only at entries already stored, so a same-edge push never
  // bypasses to the output; a flush makes any same-edge pop an underflow.
  assign pushEn    = bus.inValid & inReadyR & ~flush;
  assign popEn     = popReq & (count != 3'd0) & ~flush;
  assign popEmpty  = popReq & ~popEn;
  assign countNext = flush ? 3'd0 : count + {2'b00, pushEn} - {2'b00, popEn};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      inReadyR <= 1'b0;
    end else begin
      count    <= countNext;
      inReadyR <= (countNext != 3'(DEPTH));
      if (flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (pushEn) wrPtr <= wrPtr + 2'd1;
        if (popEn)  rdPtr <= rdPtr + 2'd1;
      end
    end
  end

  // NOTE: storage has no reset; count gates every read, so stale entries
  // are never observed.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      memI[wrPtr] <= bus.iIn;
      memQ[wrPtr] <= bus.qIn;
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      parity     <= 1'b0;
      phaseCnt   <= '0;
      latEven    <= '0;
      latOdd     <= '0;
      latMid     <= '0;
      symEnR     <= 1'b0;
      sym2xEnR   <= 1'b0;
      symEnEvenR <= 1'b0;
      iOutR      <= '0;
      qOutR      <= '0;
      underflow  <= 1'b0;
    end else begin
      // Dropping run abandons the symbol at this edge, from either state.
      state    <= run ? RUN : IDLE;
      parity   <= nextParity;
      phaseCnt <= nextPhase;

      // Configuration is captured as each symbol begins, so mid-symbol
      // changes wait for the next symbol strobe.
      if (startSym) begin
        latEven <= symPeriodEven;
        latOdd  <= symPeriodOdd;
        latMid  <= midOffset;
      end

      symEnR     <= startSym;
      sym2xEnR   <= popReq;
      symEnEvenR <= startSym & ~nextParity;

      if (popEn) begin
        iOutR <= memI[rdPtr];
        qOutR <= memQ[rdPtr];
      end

      // A new run clears the flag, but an underflow on its very first
      // strobe must still be reported.
      if (enterRun)      underflow <= popEmpty;
      else if (popEmpty) underflow <= 1'b1;
    end
  end

`ifdef MULTIH_SEQ_UNDERFLOW_CNT_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      underflowCnt <= '0;
    end else if (enterRun) begin
      underflowCnt <= {7'd0, popEmpty};
    end else if (popEmpty && underflowCnt != 8'hFF) begin
      underflowCnt <= underflowCnt + 8'd1;
    end
  end
`endif

  assign bus.inReady   = inReadyR;
  assign bus.symEn     = symEnR;
  assign bus.sym2xEn   = sym2xEnR;
  assign bus.symEnEven = symEnEvenR;
  assign bus.iOut      = iOutR;
  assign bus.qOut      = qOutR;

endmodule

// File: tb/tb_multih_sym_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multih_sym_sequencer
//
// Self-checking bench for multih_sym_sequencer. A behavioural model tracks
// symbols by their start cycle and length, and the FIFO as a queue; a compare
// process checks every DUT output against it on each falling edge. Directed
// scenarios add literal, hand-computed expectations at key cycles.
// ---------------------------------------------------------------------------
module tb_multih_sym_sequencer;
  localparam int DATA_W = 18;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             resetN = 1'b0;
  logic             run = 1'b0;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] symPeriodEven = 8'd10;
  logic [CNT_W-1:0] symPeriodOdd  = 8'd9;
  logic [CNT_W-1:0] midOffset     = 8'd2;
  logic             underflow;
`ifdef MULTIH_SEQ_UNDERFLOW_CNT_EN
  logic [7:0]       underflowCnt;
`endif

  multih_sym_sequencer_if #(.DATA_W(DATA_W)) bus ();

  multih_sym_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .run           (run),
    .flush         (flush),
    .symPeriodEven (symPeriodEven),
    .symPeriodOdd  (symPeriodOdd),
    .midOffset     (midOffset),
    .bus           (bus),
    .underflow     (underflow)
`ifdef MULTIH_SEQ_UNDERFLOW_CNT_EN
    ,
    .underflowCnt  (underflowCnt)
`endif
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model
  // -------------------------------------------------------------------------
  int                     now;        // index of the cycle after the current edge
  bit                     mRun;
  bit                     mOdd;
  int                     symStart;
  int                     symLen;
  int                     symMid;
  logic                   eSym, e2x, eEven, eUf, mReady;
  logic [DATA_W-1:0]      eI, eQ;
  int                     eCnt;
  logic [2*DATA_W-1:0]    q [$];

  task automatic beginSymbol();
    int raw;
    raw      = mOdd ? int'(symPeriodOdd) : int'(symPeriodEven);
    symLen   = (raw < 4) ? 4 : raw;
    symMid   = (midOffset == 0 || int'(midOffset) >= symLen) ? symLen / 2 : int'(midOffset);
    symStart = now;
  endtask

  task automatic modelReset();
    now = 0; mRun = 0; mOdd = 0;
    eSym = 0; e2x = 0; eEven = 0; eUf = 0; mReady = 0;
    eI = '0; eQ = '0; eCnt = 0;
    q.delete();
  endtask

  task automatic modelStep();
    now++;
    eSym = 0; e2x = 0; eEven = 0;
    if (!run) begin
      mRun = 0;
    end else if (!mRun) begin
      mRun = 1; mOdd = 0; eUf = 0; eCnt = 0;
      beginSymbol();
      eSym = 1; e2x = 1; eEven = 1;
    end else if (now - symStart == symLen) begin
      mOdd = !mOdd;
      beginSymbol();
      eSym = 1; e2x = 1; eEven = !mOdd;
    end else if (now - symStart == symMid) begin
      e2x = 1;
    end
    if (e2x) begin
      if (flush || q.size() == 0) begin
        eUf = 1;
        if (eCnt < 255) eCnt++;
      end else begin
        {eI, eQ} = q.pop_front();
      end
    end
    if (flush) q.delete();
    if (bus.inValid && mReady && !flush) q.push_back({bus.iIn, bus.qIn});
    mReady = (q.size() < 4);
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge resetN);
      if (!resetN) modelReset();
      else         modelStep();
    end
  end

  // Compare process: outputs settle after the rising edge, checked on the fall.
  initial begin
    forever begin
      @(negedge clk);
      check("symEn",     bus.symEn,     eSym);
      check("sym2xEn",   bus.sym2xEn,   e2x);
      check("symEnEven", bus.symEnEven, eEven);
      check("iOut",      bus.iOut,      eI);
      check("qOut",      bus.qOut,      eQ);
      check("inReady",   bus.inReady,   mReady);
      check("underflow", underflow,     eUf);
`ifdef MULTIH_SEQ_UNDERFLOW_CNT_EN
      check("underflowCnt", underflowCnt, 64'(eCnt));
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  int seqNo = 0;
  bit feed  = 0;

  task automatic tick();
    @(negedge clk);
    seqNo++;
    if (feed) begin
      bus.iIn = DATA_W'(seqNo * 37 + 5);
      bus.qIn = DATA_W'(seqNo * 101) ^ 18'h2AAAA;
    end
  endtask

  initial begin
    bus.iIn = '0;
    bus.qIn = '0;
    bus.inValid = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_symEn",     bus.symEn,     0);
    check("rst_sym2xEn",   bus.sym2xEn,   0);
    check("rst_symEnEven", bus.symEnEven, 0);
    check("rst_inReady",   bus.inReady,   0);
    check("rst_iOut",      bus.iOut,      0);
    check("rst_underflow", underflow,     0);
    resetN = 1'b1;
    tick();
    check("post_rst_inReady", bus.inReady, 1);

    // Backpressure: strobes stopped, four samples fill the FIFO
    feed = 1;
    bus.inValid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("bp_inReady", bus.inReady, (i < 4) ? 1 : 0);
    end

    // Nominal pattern 10/9/2; run dropped at phaseCnt=1 of the third even symbol
    run = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      tick();
      check("nom_symEn",     bus.symEn,     (k inside {0, 10, 19, 29, 38}) ? 1 : 0);
      check("nom_sym2xEn",   bus.sym2xEn,   (k inside {0, 2, 10, 12, 19, 21, 29, 31, 38}) ? 1 : 0);
      check("nom_symEnEven", bus.symEnEven, (k inside {0, 19, 38}) ? 1 : 0);
      if (k == 0) check("nom_inReady_after_pop", bus.inReady, 1);
      if (k == 1) check("nom_inReady_refull",    bus.inReady, 0);
      if (k == 39) run = 1'b0;
    end
    tick();
    tick();

    // Configuration change in the middle of an even symbol
    run = 1'b1;
    for (int k = 0; k <= 26; k++) begin
      tick();
      if (k == 5) begin
        symPeriodEven = 8'd6;
        midOffset     = 8'd3;
      end
      if (k == 6)  check("cfg_no_early_symEn", bus.symEn,     0);
      if (k == 10) check("cfg_symEn_10",       bus.symEn,     1);
      if (k == 12) check("cfg_old_mid_gone",   bus.sym2xEn,   0);
      if (k == 13) check("cfg_new_mid_13",     bus.sym2xEn,   1);
      if (k == 19) check("cfg_even_19",        bus.symEnEven, 1);
      if (k == 25) check("cfg_symEn_25",       bus.symEn,     1);
    end

    // Asynchronous reset between edges while running
    @(posedge clk);
    #3;
    resetN = 1'b0;
    #1;
    check("arst_symEn",     bus.symEn,     0);
    check("arst_sym2xEn",   bus.sym2xEn,   0);
    check("arst_symEnEven", bus.symEnEven, 0);
    check("arst_iOut",      bus.iOut,      0);
    check("arst_qOut",      bus.qOut,      0);
    check("arst_inReady",   bus.inReady,   0);
    feed = 0;
    bus.inValid = 1'b0;
    symPeriodEven = 8'd4;
    symPeriodOdd  = 8'd4;
    midOffset     = 8'd0;
    @(negedge clk);
    resetN = 1'b1;

    // Underflow: empty FIFO after reset, strobes every two clocks
    for (int k = 0; k < 600; k++) begin
      tick();
      if (k == 0) begin
        check("uf_first_strobe", bus.sym2xEn, 1);
        check("uf_flag_first",   underflow,   1);
        check("uf_iOut_first",   bus.iOut,    0);
      end
    end
    check("uf_flag",    underflow, 1);
    check("uf_iOut",    bus.iOut,  0);
    check("uf_qOut",    bus.qOut,  0);
`ifdef MULTIH_SEQ_UNDERFLOW_CNT_EN
    check("uf_cnt_sat", underflowCnt, 255);
`endif

    // Restart with clamped periods: even 10 / odd 2->4 / mid 12 -> 5 and 2
    run = 1'b0;
    feed = 1;
    bus.inValid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("idle_keeps_underflow", underflow, 1);
    symPeriodEven = 8'd10;
    symPeriodOdd  = 8'd2;
    midOffset     = 8'd12;
    run = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      tick();
      if (k == 0) begin
        check("rs_symEnEven_first", bus.symEnEven, 1);
        check("rs_underflow_clr",   underflow,     0);
      end
      if (k == 5)  check("clamp_mid_5",      bus.sym2xEn,   1);
      if (k == 10) check("clamp_odd_start",  bus.symEn,     1);
      if (k == 10) check("clamp_odd_noeven", bus.symEnEven, 0);
      if (k == 12) check("clamp_odd_mid",    bus.sym2xEn,   1);
      if (k == 14) check("clamp_odd_len4",   bus.symEnEven, 1);
    end

    // Flush with a concurrent push while running
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 20; k++) tick();

    run = 1'b0;
    bus.inValid = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
